mix_columns_iter: RTL
=====================

# mix_columns_iter

Iterative AES MixColumns stage with valid/ready handshakes, placed directly downstream of the row-shift stage in the round datapath. It accepts one 128-bit state and transforms it one column per cycle through a single shared GF(2^8) column unit. It holds the result until the next stage (AddRoundKey) takes it. For the final round the column transform is bypassed so that every round shows the same latency.

## Interface
- word_size, 8, byte width; only 8 is supported (GF(2^8) arithmetic).
- array_size, 16, bytes per state; only 16 is supported.
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- In_Valid  in  1  upstream holds Data/Last_Round valid.
- In_Ready  out  1  stage can accept a state.
- Data  in  [0:word_size*array_size-1]  column-major state: byte k = 4*col+row at Data[k*8 +: 8], so byte 0 is Data[0:7].
- Last_Round  in  1  sampled with Data; 1 means a pass-through copy (no MixColumns).
- Out_Valid  out  1  Mixed_Data holds a complete result.
- Out_Ready  in  1  downstream accepts the result.
- Mixed_Data  out  [0:word_size*array_size-1]  result, same byte layout as Data.
- Decrypt  in  1  present only with INV_MIX_COLUMNS_EN; sampled with Data.

## Operation
- Clock and reset are fixed: one clock, reset is asynchronous and active-low.
- FSM states:
  - IDLE: In_Ready=1. On In_Valid&&In_Ready, capture Data, Last_Round and Decrypt into the work register, clear col_cnt, go to MIX.
  - MIX: on each edge, transform column col_cnt and write it into the result register; col_cnt increments by 1. After col_cnt==3, go to DONE.
  - DONE: Out_Valid=1. On Out_Ready, go to IDLE.
- In_Ready is 1 only in IDLE. Data and Last_Round are ignored in MIX and DONE.
- xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00). Every product is built from xtime and XOR; all arithmetic is mod 2^8, no carries.
- Forward column (a0..a3 are rows 0..3):
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
- Last_Round=1: r = a for every column. Cycle count is unchanged.
- Mixed_Data is guaranteed only while Out_Valid=1. It stays stable in DONE until the handshake completes.

## Timing
- Reset values: Out_Valid=0, Mixed_Data=0, state IDLE, In_Ready=1 (also during reset), col_cnt=0.
- Reset asserted in any state aborts the operation immediately. The partial result is discarded; no Out_Valid follows reset release.
- Latency, with the accept edge as edge 0:
  - MIX edges are 1 to 4.
  - Out_Valid rises after edge 4.
  - First cycle Out_Ready can complete the handshake is the cycle after edge 4.
- Throughput: at most one state per 6 cycles when Out_Ready is held at 1 (accept, 4 MIX, DONE handshake, then IDLE).
- Out_Valid stays high until Out_Ready=1 is sampled. Out_Ready toggling in IDLE or MIX has no effect.
- In_Valid is not required to drop after acceptance. Upstream may present the next state immediately; it is accepted only once back in IDLE.
- Out_Valid falls on the handshake edge. In_Ready rises on the same edge (state becomes IDLE).

## Configuration
- INV_MIX_COLUMNS_EN defined:
  - Port Decrypt exists.
  - Decrypt=1 with Last_Round=0 applies InvMixColumns with row coefficients {0e,0b,0d,09}, rotated per row as in the forward matrix.
  - Products are built from chained xtime.
  - Latency is identical to the forward transform.
- INV_MIX_COLUMNS_EN undefined: no Decrypt port, forward transform only, and no inverse logic is synthesised.

## Test plan
- Reset mid-MIX (assert rst_n=0 at MIX edge 2) -> Out_Valid=0, Mixed_Data=0, In_Ready=1 at once. The next accepted state yields a correct result.
- FIPS-197 round 1: Data=d4bf5d30e0b452aeb84111f11e2798e5, Last_Round=0, Out_Ready=1 -> Out_Valid in the cycle after edge 4, Mixed_Data=046681e5e0cb199a48f8d37a2806264c.
- Column identities: Data=db135345f20a225c01010101c6c6c6c6 -> Mixed_Data=8e4da1bc9fdc589d01010101c6c6c6c6.
- Last_Round=1, Data=00112233445566778899aabbccddeeff -> same value at Mixed_Data, same 4-cycle latency.
- Backpressure: Out_Ready=0 for 10 cycles with In_Valid held high -> Out_Valid and Mixed_Data stable, In_Ready=0. When Out_Ready=1, the next state is accepted the cycle after the handshake.
- With INV_MIX_COLUMNS_EN, Decrypt=1: Data=8e4da1bc9fdc589d01010101c6c6c6c6 -> Mixed_Data=db135345f20a225c01010101c6c6c6c6.

Source files
------------

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - iterative AES MixColumns, one column per cycle, valid/ready on both sides
// Optional InvMixColumns support is enabled by defining INV_MIX_COLUMNS_EN (adds the Decrypt port).
module mix_columns_iter #(
  parameter int word_size  = 8,
  parameter int array_size = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                In_Valid,
  output logic                                In_Ready,
  input  logic [0:word_size*array_size-1]     Data,
  input  logic                                Last_Round,
`ifdef INV_MIX_COLUMNS_EN
  input  logic                                Decrypt,
`endif
  output logic                                Out_Valid,
  input  logic                                Out_Ready,
  output logic [0:word_size*array_size-1]     Mixed_Data
);

  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

  state_t state, next_state;
  logic [0:word_size*array_size-1] work_q;
  logic [0:word_size*array_size-1] result_q;
  logic [1:0]  col_cnt;
  logic        last_q;
  logic        accept;
  logic [31:0] col_in;
  logic [31:0] col_out;
`ifdef INV_MIX_COLUMNS_EN
  logic        dec_q;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column packed as {a0,a1,a2,a3}, row 0 in the top byte.
  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    mix_fwd = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
               xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

`ifdef INV_MIX_COLUMNS_EN
  // 09 = 8+1, 0b = 8+2+1, 0d = 8+4+1, 0e = 8+4+2 from the xtime chain.
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    {a[0], a[1], a[2], a[3]} = c;
    for (int i = 0; i < 4; i++) begin
      x2 = xtime(a[i]);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    mix_inv = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
               m9[0] ^ me[1] ^ mb[2] ^ md[3],
               md[0] ^ m9[1] ^ me[2] ^ mb[3],
               mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    In_Ready   = 1'b0;
    Out_Valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        In_Ready = 1'b1;
        if (In_Valid) begin
          accept     = 1'b1;
          next_state = MIX;
        end
      end
      MIX: begin
        if (col_cnt == 2'd3) next_state = DONE;
      end
      DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign col_in = work_q[{col_cnt, 5'b0} +: 32];

  always_comb begin
    col_out = col_in;
`ifdef INV_MIX_COLUMNS_EN
    if (!last_q) col_out = dec_q ? mix_inv(col_in) : mix_fwd(col_in);
`else
    if (!last_q) col_out = mix_fwd(col_in);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q   <= '0;
      result_q <= '0;
      col_cnt  <= 2'd0;
      last_q   <= 1'b0;
`ifdef INV_MIX_COLUMNS_EN
      dec_q    <= 1'b0;
`endif
    end else if (accept) begin
      work_q  <= Data;
      last_q  <= Last_Round;
      col_cnt <= 2'd0;
`ifdef INV_MIX_COLUMNS_EN
      dec_q   <= Decrypt;
`endif
    end else if (state == MIX) begin
      result_q[{col_cnt, 5'b0} +: 32] <= col_out;
      col_cnt <= col_cnt + 2'd1;
    end
  end

  assign Mixed_Data = result_q;

endmodule
